multicycle_controller: RTL

Sequencing control unit for the multicycle RISC-V core. It replaces the hard-wired enables of the single-cycle top with a Moore FSM, plus a small Mealy branch term. It steps each instruction through fetch, decode, execute, memory and writeback, and drives the PC, instruction register, register file, data memory, ALU, result muxes and immediate extender. It supports lw, sw, R-type, I-type ALU, beq and jal, traps on anything else, and counts retired instructions.

---
 rtl/multicycle_controller.sv | 256 +++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - Moore sequencing FSM with Mealy branch term for a multicycle RISC-V core
//
// Steps each instruction through fetch/decode/execute/memory/writeback and
// drives the datapath enables and mux selects. Supports lw, sw, R-type,
// I-type ALU, beq and jal. Anything else parks the FSM in TRAP until reset.
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous, active-low reset
//   op             instr[6:0] from the instruction register
//   funct3         instr[14:12]
//   funct7b5       instr[30]
//   zero           ALU zero flag
//   pc_write       PC register enable
//   adr_src        memory address select (0 = PC, 1 = ALUOut)
//   mem_write      data memory write enable
//   ir_write       instruction register / OldPC enable
//   reg_write      register file WE3
//   result_src     result mux (00 ALUOut, 01 mem data, 10 ALU result)
//   alu_src_a      ALU A select (00 PC, 01 OldPC, 10 RD1)
//   alu_src_b      ALU B select (00 RD2, 01 immExt, 10 constant 4)
//   alu_control    ALU op (000 add, 001 sub, 010 and, 011 or, 101 slt)
//   imm_src        immediate extender select (00 I, 01 S, 10 B, 11 J)
//   illegal        high while in TRAP
//   retire_count   number of retired instructions (wraps)

module multicycle_controller #(
    parameter logic [3:0] RESET_STATE_ENC = 4'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  op,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic        zero,
    output logic        pc_write,
    output logic        adr_src,
    output logic        mem_write,
    output logic        ir_write,
    output logic        reg_write,
    output logic [1:0]  result_src,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [2:0]  alu_control,
    output logic [1:0]  imm_src,
    output logic        illegal,
    output logic [31:0] retire_count
);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    // Encodings are derived from the FETCH encoding by XOR so that any
    // choice of RESET_STATE_ENC still yields twelve distinct codes.
    typedef enum logic [3:0] {
        S_FETCH    = RESET_STATE_ENC,
        S_DECODE   = RESET_STATE_ENC ^ 4'd1,
        S_MEMADR   = RESET_STATE_ENC ^ 4'd2,
        S_MEMREAD  = RESET_STATE_ENC ^ 4'd3,
        S_MEMWB    = RESET_STATE_ENC ^ 4'd4,
        S_MEMWRITE = RESET_STATE_ENC ^ 4'd5,
        S_EXECR    = RESET_STATE_ENC ^ 4'd6,
        S_EXECI    = RESET_STATE_ENC ^ 4'd7,
        S_ALUWB    = RESET_STATE_ENC ^ 4'd8,
        S_BEQ      = RESET_STATE_ENC ^ 4'd9,
        S_JAL      = RESET_STATE_ENC ^ 4'd10,
        S_TRAP     = RESET_STATE_ENC ^ 4'd11
    } state_e;

    state_e      state_q, state_d;
    state_e      decode_target;
    state_e      state_view;
    logic [31:0] retire_q, retire_d;
    logic        retire;
    logic        alu_f3_ok;

    logic        pc_update;
    logic        branch;
    logic        ir_w;
    logic        reg_w;
    logic        mem_w;
    logic [1:0]  alu_op;

    // ---------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------
    assign alu_f3_ok = (funct3 == 3'b000) || (funct3 == 3'b010) ||
                       (funct3 == 3'b110) || (funct3 == 3'b111);

    always_comb begin
        decode_target = S_TRAP;
        case (op)
            OP_LW, OP_SW: decode_target = (funct3 == 3'b010) ? S_MEMADR : S_TRAP;
            OP_R:         decode_target = alu_f3_ok ? S_EXECR : S_TRAP;
            OP_I:         decode_target = alu_f3_ok ? S_EXECI : S_TRAP;
            OP_BEQ:       decode_target = (funct3 == 3'b000) ? S_BEQ : S_TRAP;
            OP_JAL:       decode_target = S_JAL;
            default:      decode_target = S_TRAP;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    state_d = S_DECODE;
            S_DECODE:   state_d = decode_target;
            S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = S_FETCH;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_TRAP:     state_d = S_TRAP;
            // Unused codes indicate corrupted state; park where it is visible.
            default:    state_d = S_TRAP;
        endcase
    end

    // The last state of every supported instruction retires it on exit.
    assign retire   = (state_q == S_MEMWB) || (state_q == S_MEMWRITE) ||
                      (state_q == S_ALUWB) || (state_q == S_BEQ);
    assign retire_d = retire_q + {31'd0, retire};

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_FETCH;
            retire_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            retire_q <= retire_d;
        end
    end

    // ---------------------------------------------------------------
    // Output decode
    // ---------------------------------------------------------------
    // While reset is low the outputs present FETCH values, with the
    // write enables masked off below.
    assign state_view = reset ? state_q : S_FETCH;

    always_comb begin
        pc_update  = 1'b0;
        branch     = 1'b0;
        ir_w       = 1'b0;
        reg_w      = 1'b0;
        mem_w      = 1'b0;
        adr_src    = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        illegal    = 1'b0;
        case (state_view)
            S_FETCH: begin
                ir_w       = 1'b1;
                pc_update  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
            end
            S_DECODE: begin
                // OldPC + immExt: branch target ready for BEQ.
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_w      = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src = 1'b1;
                mem_w   = 1'b1;
            end
            S_EXECR: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
            end
            S_EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
            end
            S_ALUWB: begin
                reg_w = 1'b1;
            end
            S_BEQ: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                branch    = 1'b1;
            end
            S_JAL: begin
                // ALU forms OldPC + 4 as the link value while PC takes the target.
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_update = 1'b1;
            end
            S_TRAP: begin
                illegal = 1'b1;
            end
            default: begin
                illegal = 1'b0;
            end
        endcase
    end

    assign pc_write  = reset & (pc_update | (branch & zero));
    assign ir_write  = reset & ir_w;
    assign reg_write = reset & reg_w;
    assign mem_write = reset & mem_w;

    // ALU decoder. Only R-type (op[5]=1) can select sub via funct7b5;
    // I-type addi with instr[30] set remains an add.
    always_comb begin
        alu_control = 3'b000;
        case (alu_op)
            2'b00: alu_control = 3'b000;
            2'b01: alu_control = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  alu_control = (op[5] & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  alu_control = 3'b101;
                    3'b110:  alu_control = 3'b011;
                    3'b111:  alu_control = 3'b010;
                    default: alu_control = 3'b000;
                endcase
            end
            default: alu_control = 3'b000;
        endcase
    end

    always_comb begin
        imm_src = 2'b00;
        case (op)
            OP_SW:   imm_src = 2'b01;
            OP_BEQ:  imm_src = 2'b10;
            OP_JAL:  imm_src = 2'b11;
            default: imm_src = 2'b00;
        endcase
    end

    assign retire_count = retire_q;

endmodule
